// File: rtl/regfile_loader_pkg.sv
// rtl/regfile_loader_pkg.sv - shared widths, batch depth and loader state encoding
package regfile_loader_pkg;

   localparam int DATA_W  = 16;
   localparam int ADDR_W  = 3;
   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 64;

   typedef enum logic {
      LOAD = 1'b0,
      SCAN = 1'b1
   } state_t;

endpackage

// File: rtl/regfile_loader_if.sv
// rtl/regfile_loader_if.sv - upstream word stream (valid/ready/data) into the loader
interface regfile_loader_if #(
   parameter int DATA_W = regfile_loader_pkg::DATA_W
) ();

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready
   );

endinterface

// File: rtl/regfile_loader_watchdog.sv
// rtl/regfile_loader_watchdog.sv - SCAN timeout counter; expiry pulses on the last counted cycle
module loader_watchdog
   import regfile_loader_pkg::*;
#(
   parameter int TIMEOUT = regfile_loader_pkg::TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_en,
   output logic o_expire
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] r_cnt;
   logic          w_expire;

   assign w_expire = i_en && !i_clear && (r_cnt == LAST);
   assign o_expire = w_expire;

   // Self-clears on expiry so a non power-of-two TIMEOUT restarts cleanly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clear || w_expire) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/regfile_loader.sv
// rtl/regfile_loader.sv - writes each batch of DEPTH words into the register file, then waits for the scan result
module regfile_loader
   import regfile_loader_pkg::*;
#(
   parameter int DATA_W  = regfile_loader_pkg::DATA_W,
   parameter int ADDR_W  = regfile_loader_pkg::ADDR_W,
   parameter int DEPTH   = regfile_loader_pkg::DEPTH,
   parameter int TIMEOUT = regfile_loader_pkg::TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   regfile_loader_if.slave   s_in,
   input  logic              flush,
   input  logic              scan_valid,
   output logic              WriteEn,
   output logic [ADDR_W-1:0] WriteReg,
   output logic [DATA_W-1:0] WriteData,
   output logic              batch_done,
   output logic              busy,
   output logic              err_timeout
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            r_state;
   logic [ADDR_W-1:0] r_cnt;
   logic              w_ready;
   logic              w_hs;
   logic              w_wd_clear;
   logic              w_wd_en;
   logic              w_wd_expire;

   assign w_ready        = (r_state == LOAD) && !flush && !rst;
   assign s_in.in_ready  = w_ready;
   assign w_hs           = s_in.in_valid && w_ready;

   assign w_wd_en    = (r_state == SCAN);
   assign w_wd_clear = flush || (r_state != SCAN) || scan_valid;

   loader_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (w_wd_clear),
      .i_en     (w_wd_en),
      .o_expire (w_wd_expire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= LOAD;
         r_cnt       <= '0;
         WriteEn     <= 1'b0;
         WriteReg    <= '0;
         WriteData   <= '0;
         batch_done  <= 1'b0;
         busy        <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         WriteEn    <= 1'b0;
         batch_done <= 1'b0;
         if (flush) begin
            r_state <= LOAD;
            r_cnt   <= '0;
            busy    <= 1'b0;
         end else begin
            case (r_state)
               LOAD: begin
                  if (w_hs) begin
                     WriteEn   <= 1'b1;
                     WriteReg  <= r_cnt;
                     WriteData <= s_in.in_data;
                     r_cnt     <= r_cnt + 1'b1;
                     // The final write of the batch lands in the first SCAN cycle.
                     if (r_cnt == LAST_ADDR) begin
                        r_state <= SCAN;
                        busy    <= 1'b1;
                     end
                  end
               end
               SCAN: begin
                  if (scan_valid) begin
                     batch_done <= 1'b1;
                     r_state    <= LOAD;
                     busy       <= 1'b0;
                  end else if (w_wd_expire) begin
                     err_timeout <= 1'b1;
                     r_state     <= LOAD;
                     busy        <= 1'b0;
                  end
               end
               default: begin
                  r_state <= LOAD;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_regfile_loader.sv
// tb/tb_regfile_loader.sv - scoreboard bench: stimulus queues expected writes/pulses, monitor pops and compares
module tb_regfile_loader;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        scan_valid;
   logic        WriteEn;
   logic [2:0]  WriteReg;
   logic [15:0] WriteData;
   logic        batch_done;
   logic        busy;
   logic        err_timeout;

   regfile_loader_if #(.DATA_W(16)) in_if ();

   regfile_loader dut (
      .clk         (clk),
      .rst         (rst),
      .s_in        (in_if),
      .flush       (flush),
      .scan_valid  (scan_valid),
      .WriteEn     (WriteEn),
      .WriteReg    (WriteReg),
      .WriteData   (WriteData),
      .batch_done  (batch_done),
      .busy        (busy),
      .err_timeout (err_timeout)
   );

   typedef struct {
      bit          is_done;
      logic [2:0]  addr;
      logic [15:0] data;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [2:0]  exp_addr = 3'd0;

   logic [15:0] vec_a [8] = '{16'h0005, 16'h0010, 16'hFFFF, 16'h0000,
                              16'h1234, 16'h0007, 16'h8000, 16'h0001};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic pop_check(input bit is_done, input logic [2:0] addr, input logic [15:0] data);
      exp_t e;
      n_cmp++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL sb_unexpected: got %s addr=%0d data=0x%0h, expected nothing",
                  is_done ? "batch_done" : "write", addr, data);
      end else begin
         e = sb.pop_front();
         if (e.is_done != is_done || (!is_done && (e.addr !== addr || e.data !== data))) begin
            n_fail++;
            $display("FAIL sb_event: got %s addr=%0d data=0x%0h, expected %s addr=%0d data=0x%0h",
                     is_done ? "batch_done" : "write", addr, data,
                     e.is_done ? "batch_done" : "write", e.addr, e.data);
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (WriteEn)    pop_check(1'b0, WriteReg, WriteData);
         if (batch_done) pop_check(1'b1, 3'd0, 16'h0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] d);
      exp_t e;
      in_if.in_valid = 1'b1;
      in_if.in_data  = d;
      e.is_done = 1'b0;
      e.addr    = exp_addr;
      e.data    = d;
      sb.push_back(e);
      exp_addr = exp_addr + 3'd1;
      tick();
      in_if.in_valid = 1'b0;
   endtask

   task automatic expect_done();
      exp_t e;
      e.is_done = 1'b1;
      e.addr    = 3'd0;
      e.data    = 16'h0;
      sb.push_back(e);
   endtask

   initial begin
      rst            = 1'b1;
      flush          = 1'b0;
      scan_valid     = 1'b0;
      in_if.in_valid = 1'b0;
      in_if.in_data  = 16'h0;
      repeat (3) tick();
      check("reset_in_ready", 32'(in_if.in_ready), 32'd0);
      check("reset_outputs", {WriteEn, WriteReg, WriteData, batch_done, busy, err_timeout}, 32'd0);
      rst = 1'b0;
      tick();
      check("idle_in_ready", 32'(in_if.in_ready), 32'd1);

      // Full batch, then a single scan_valid pulse
      for (int i = 0; i < 8; i++) send(vec_a[i]);
      check("scan_busy", 32'(busy), 32'd1);
      check("scan_in_ready", 32'(in_if.in_ready), 32'd0);
      scan_valid = 1'b1;
      expect_done();
      tick();
      scan_valid = 1'b0;
      check("after_done_in_ready", 32'(in_if.in_ready), 32'd1);
      check("after_done_busy", 32'(busy), 32'd0);
      tick();

      // in_valid on alternate cycles
      for (int i = 0; i < 8; i++) begin
         send(16'hA000 + 16'(i));
         if (i < 7) tick();
      end
      scan_valid = 1'b1;
      expect_done();
      tick();
      scan_valid = 1'b0;
      tick();

      // flush collides with a handshake
      for (int i = 0; i < 3; i++) send(16'h0300 + 16'(i));
      in_if.in_valid = 1'b1;
      in_if.in_data  = 16'hDEAD;
      flush          = 1'b1;
      #1;
      check("flush_in_ready", 32'(in_if.in_ready), 32'd0);
      tick();
      in_if.in_valid = 1'b0;
      flush          = 1'b0;
      exp_addr       = 3'd0;
      send(16'h4444);
      tick();
      flush = 1'b1;
      tick();
      flush    = 1'b0;
      exp_addr = 3'd0;

      // Timeout with scan_valid held low
      for (int i = 0; i < 8; i++) send(16'h5000 + 16'(i));
      repeat (63) tick();
      check("pre_timeout_err", 32'(err_timeout), 32'd0);
      check("pre_timeout_busy", 32'(busy), 32'd1);
      tick();
      check("timeout_err", 32'(err_timeout), 32'd1);
      check("timeout_busy", 32'(busy), 32'd0);
      check("timeout_in_ready", 32'(in_if.in_ready), 32'd1);

      // Next batch: scan_valid held for 4 cycles gives one pulse
      for (int i = 0; i < 8; i++) send(16'h6000 + 16'(i));
      scan_valid = 1'b1;
      expect_done();
      repeat (4) tick();
      scan_valid = 1'b0;
      tick();
      check("err_sticky", 32'(err_timeout), 32'd1);

      // Asynchronous reset mid-batch with a handshake pending
      for (int i = 0; i < 5; i++) send(16'h7000 + 16'(i));
      tick();
      in_if.in_valid = 1'b1;
      in_if.in_data  = 16'hBEEF;
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_outputs", {WriteEn, WriteReg, WriteData, batch_done, busy, err_timeout}, 32'd0);
      check("async_rst_in_ready", 32'(in_if.in_ready), 32'd0);
      in_if.in_valid = 1'b0;
      tick();
      rst      = 1'b0;
      exp_addr = 3'd0;
      tick();
      send(16'h0ABC);
      repeat (3) tick();

      n_cmp++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_leftover: got %0d pending events, expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_loader.md
Name: regfile_loader

Overview:
- Write-side producer for the 8-entry x 16-bit register file and min/max scan unit.
- Accepts a stream of words from an upstream source over a valid/ready handshake.
- Issues one write per word (WriteEn/WriteReg/WriteData) to addresses 0..7 in order, then stops accepting input until the scan unit reports Valid.
- Signals batch completion, and flags a timeout if Valid never arrives.

Parameters:
- DATA_W, 16, data word width
- ADDR_W, 3, register address width
- DEPTH, 8, words per batch (must equal 2**ADDR_W)
- TIMEOUT, 64, cycles to wait in SCAN for scan_valid before raising err_timeout

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream word available
- in_ready  output  1  loader can accept a word this cycle
- in_data  input  DATA_W  upstream word
- flush  input  1  synchronous discard of the partial batch
- scan_valid  input  1  Valid from the min/max unit (scan of current batch complete)
- WriteEn  output  1  register file write enable
- WriteReg  output  ADDR_W  register file write address
- WriteData  output  DATA_W  register file write data
- batch_done  output  1  one-cycle pulse when the scan result is valid for this batch
- busy  output  1  high in SCAN
- err_timeout  output  1  sticky; set on SCAN timeout

Behaviour:
- Reset (async, rst=1): state=LOAD, cnt=0, wdog=0.
  - WriteEn=0, WriteReg=0, WriteData=0.
  - batch_done=0, busy=0, err_timeout=0.
  - in_ready=0 while rst is asserted.
- All outputs except in_ready are registered. in_ready is a combinational decode of state (LOAD & !flush).
- States: LOAD, SCAN.
- LOAD:
  - in_ready=1.
  - Handshake fires on in_valid & in_ready. Next cycle: WriteEn=1, WriteReg=cnt, WriteData=in_data.
  - Latency is 1 cycle from handshake to write. Back-to-back handshakes give back-to-back writes.
  - Cycles with no handshake: WriteEn=0. WriteReg and WriteData hold their last values.
  - Handshake with cnt=DEPTH-1: cnt wraps to 0 and state goes to SCAN in the same edge. The last write is still issued in the first SCAN cycle.
- SCAN:
  - in_ready=0, busy=1.
  - wdog increments each cycle.
  - scan_valid=1 -> batch_done=1 for exactly one cycle, then state=LOAD and wdog=0. A scan_valid held high for several cycles produces only one pulse.
  - wdog reaches TIMEOUT-1 with no scan_valid -> err_timeout=1 (sticky until rst), then state=LOAD and wdog=0. No batch_done is generated.
  - scan_valid in LOAD is ignored.
- flush (synchronous, any state):
  - Sets cnt=0, state=LOAD, wdog=0, WriteEn=0 next cycle.
  - flush and handshake in the same cycle: flush wins, the word is not accepted (in_ready is forced 0).
  - flush in SCAN abandons the wait with no batch_done.
- Reset mid-batch: all progress lost. A pending write is not issued.
- Width rules: cnt is ADDR_W bits and wraps naturally. wdog is $clog2(TIMEOUT) bits. WriteData passes in_data unchanged, no sign handling.

Decomposition:
- Shared package holds:
  - state enum {LOAD, SCAN}
  - DATA_W and ADDR_W defaults, shared with the register file and min/max finder
- One natural sub-module: loader_watchdog, the SCAN timeout counter with clear/enable and an expiry pulse.
- Address counter and FSM stay in the top module.

Test Plan:
- Reset then 8 consecutive handshakes, data 0x0005, 0x0010, 0xFFFF, 0x0000, 0x1234, 0x0007, 0x8000, 0x0001.
  - Expect writes to addresses 0..7 with that data, one cycle after each handshake.
  - busy=1 after the 8th handshake and in_ready=0.
  - scan_valid pulse -> batch_done high exactly one cycle, then in_ready=1.
- in_valid toggled every other cycle over 8 words.
  - Expect WriteEn only in the cycles after a handshake, addresses still 0..7 in order, no gaps in numbering.
- 3 words loaded, then flush asserted together with a 4th in_valid.
  - Expect the 4th word not written.
  - Next accepted word is written to address 0.
- Full batch loaded, scan_valid held low.
  - Expect err_timeout=1 after 64 SCAN cycles, return to LOAD, no batch_done.
  - err_timeout stays 1 through the next batch until rst.
- rst asserted mid-cycle after 5 words.
  - Expect all outputs 0 immediately (asynchronous).
  - After release, the first word is written to address 0.
- scan_valid held high for 4 cycles in SCAN.
  - Expect a single batch_done pulse.
  - scan_valid still high in LOAD causes no further pulses.
